// File: rtl/pc_sequencer.sv
// Program sequencer for the fetch stage: walks a program from START_ADDR to END_ADDR,
// resolving relative branches, absolute jumps and call/return through a small return stack.
module pc_sequencer #(
    parameter int D          = 12,
    parameter int DEPTH      = 4,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         stall,
    input  logic         branch_en,
    input  logic         jump_en,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [D-1:0] target,
    input  logic [D-1:0] offset,
    output logic [D-1:0] prog_ctr,
    output logic [D-1:0] link_addr,
    output logic         running,
    output logic         done,
    output logic         stack_err
);

    localparam int           CW       = $clog2(DEPTH + 1);
    localparam logic [D-1:0] START_PC = D'(START_ADDR);
    localparam logic [D-1:0] END_PC   = D'(END_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          push_en;
    logic [D-1:0]  pc_inc;
    logic [D-1:0]  top;
    logic [D-1:0]  stack_q [DEPTH];

    // Entry cnt-1 is the top of stack; an empty stack reads as zero.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == CW'(i + 1)) begin
                top = stack_q[i];
            end
        end
    end

    always_comb begin
        pc_inc  = pc_q + D'(1);
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    state_d = ST_RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // Reaching the end address wins over stall and every control input.
                if (pc_q == END_PC) begin
                    state_d = ST_DONE;
                end else if (!stall) begin
                    if (ret_en) begin
                        if (cnt_q != '0) begin
                            pc_d  = top;
                            cnt_d = cnt_q - CW'(1);
                        end else begin
                            pc_d  = pc_inc;
                            err_d = 1'b1;
                        end
                    end else if (call_en) begin
                        pc_d = target;
                        if (cnt_q != CW'(DEPTH)) begin
                            push_en = 1'b1;
                            cnt_d   = cnt_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (jump_en) begin
                        pc_d = target;
                    end else if (branch_en) begin
                        pc_d = pc_q + offset;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_PC;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Stack storage needs no reset: entries above the count are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_en && cnt_q == CW'(i)) begin
                stack_q[i] <= pc_inc;
            end
        end
    end

    assign prog_ctr  = pc_q;
    assign link_addr = top;
    assign running   = running_q;
    assign done      = done_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts every cycle,
// a separate monitor compares the DUT outputs one edge later.
module tb_pc_sequencer;

    localparam int D     = 12;
    localparam int DEPTH = 4;
    localparam int START = 0;
    localparam int ENDA  = 'h50;
    localparam int M     = 1 << D;

    logic         clk;
    logic         reset;
    logic         req, stall, branch_en, jump_en, call_en, ret_en;
    logic [D-1:0] target, offset;
    logic [D-1:0] prog_ctr, link_addr;
    logic         running, done, stack_err;

    pc_sequencer #(
        .D(D), .DEPTH(DEPTH), .START_ADDR(START), .END_ADDR(ENDA)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .branch_en(branch_en), .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en),
        .target(target), .offset(offset),
        .prog_ctr(prog_ctr), .link_addr(link_addr),
        .running(running), .done(done), .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [D-1:0] pc;
        logic [D-1:0] link;
        logic         run;
        logic         dn;
        logic         err;
    } obs_t;

    obs_t  sb_q[$];
    string lbl_q[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model: mode 0=idle 1=run 2=done, PC as integer modulo 2^D, stack as a queue.
    int m_mode;
    int m_pc;
    int m_stack[$];
    bit m_err;

    function automatic obs_t model_view();
        obs_t o;
        o.pc   = D'(m_pc);
        o.link = (m_stack.size() > 0) ? D'(m_stack[m_stack.size() - 1]) : '0;
        o.run  = (m_mode == 1);
        o.dn   = (m_mode == 2);
        o.err  = m_err;
        return o;
    endfunction

    function automatic obs_t dut_view();
        obs_t o;
        o.pc   = prog_ctr;
        o.link = link_addr;
        o.run  = running;
        o.dn   = done;
        o.err  = stack_err;
        return o;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pc   = START;
        m_stack.delete();
        m_err  = 1'b0;
    endtask

    task automatic model_step(input bit rq, st, br, jp, cl, rt, input int tg, of);
        if (m_mode != 1) begin
            if (rq) begin
                m_mode = 1;
                m_pc   = START;
                m_stack.delete();
                m_err  = 1'b0;
            end
        end else if (m_pc == ENDA) begin
            m_mode = 2;
        end else if (!st) begin
            if (rt) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_pc  = (m_pc + 1) % M;
                    m_err = 1'b1;
                end
            end else if (cl) begin
                if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % M);
                else m_err = 1'b1;
                m_pc = tg;
            end else if (jp) begin
                m_pc = tg;
            end else if (br) begin
                m_pc = (m_pc + of) % M;
            end else begin
                m_pc = (m_pc + 1) % M;
            end
        end
    endtask

    task automatic check(input string name, input obs_t got, input obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got pc=%h link=%h run=%b done=%b err=%b, need pc=%h link=%h run=%b done=%b err=%b",
                     name, got.pc, got.link, got.run, got.dn, got.err,
                     exp.pc, exp.link, exp.run, exp.dn, exp.err);
        end
    endtask

    // Drive one cycle's inputs away from the active edge and queue the predicted outcome.
    task automatic cyc(input string name, input bit rq, st, br, jp, cl, rt,
                       input int tg, input int of);
        @(negedge clk);
        req = rq; stall = st; branch_en = br; jump_en = jp; call_en = cl; ret_en = rt;
        target = D'(tg); offset = D'(of);
        model_step(rq, st, br, jp, cl, rt, tg, of);
        sb_q.push_back(model_view());
        lbl_q.push_back(name);
    endtask

    task automatic idle_inputs();
        req = 0; stall = 0; branch_en = 0; jump_en = 0; call_en = 0; ret_en = 0;
        target = '0; offset = '0;
    endtask

    initial begin : monitor
        obs_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n = lbl_q.pop_front();
                check(n, dut_view(), e);
            end
        end
    end

    initial begin : stimulus
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #2;
        check("reset_state", dut_view(), model_view());
        #10 reset = 1'b1;

        cyc("start", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("seq_step", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("call_outer", 0, 0, 0, 0, 1, 0, 'h20, 0);
        cyc("call_nested", 0, 0, 0, 0, 1, 0, 'h30, 0);
        cyc("ret_inner", 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("ret_outer", 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("jump_10", 0, 0, 0, 1, 0, 0, 'h0A, 0);
        cyc("branch_neg3", 0, 0, 1, 0, 0, 0, 0, 'hFFD);
        cyc("jump_40", 0, 0, 0, 1, 0, 0, 'h40, 0);
        for (int i = 0; i < 5; i++) cyc("nest_call", 0, 0, 0, 0, 1, 0, 'h10 + i, 0);
        for (int i = 0; i < 5; i++) cyc("nest_ret", 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("call_prio", 0, 0, 0, 0, 1, 0, 'h30, 0);
        cyc("ret_call_jump", 0, 0, 0, 1, 1, 1, 'h10, 0);
        cyc("call_again", 0, 0, 0, 0, 1, 0, 'h22, 0);
        for (int i = 0; i < 3; i++) cyc("stall_hold", 0, 1, 1, 1, 1, 0, 'h33, 5);
        cyc("jump_fff", 0, 0, 0, 1, 0, 0, 'hFFF, 0);
        cyc("wrap_inc", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("wrap_branch", 0, 0, 1, 0, 0, 0, 0, 'hFFF);
        cyc("jump_4e", 0, 0, 0, 1, 0, 0, 'h4E, 0);
        cyc("to_4f", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("to_end", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("end_to_done", 0, 0, 0, 1, 0, 0, 'h11, 0);
        cyc("done_hold", 0, 0, 0, 0, 1, 0, 'h12, 0);
        cyc("done_hold", 0, 0, 1, 0, 0, 1, 0, 3);
        cyc("restart", 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("after_restart", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            int r;
            bit rq, st, br, jp, cl, rt;
            r  = int'($urandom_range(0, 99));
            rq = ($urandom_range(0, 99) < 4);
            st = ($urandom_range(0, 9) == 0);
            rt = (r < 15);
            cl = (r >= 10 && r < 27);
            jp = (r >= 25 && r < 35);
            br = (r >= 33 && r < 50);
            cyc("random", rq, st, br, jp, cl, rt,
                int'($urandom_range(0, 'h5F)),
                (int'($urandom_range(0, 15)) - 8 + M) % M);
        end

        cyc("pre_reset_start", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("pre_reset_step", 0, 0, 0, 1, 0, 0, 'h25, 0);
        cyc("pre_reset_call", 0, 0, 0, 0, 1, 0, 'h31, 0);
        @(posedge clk);
        #3;
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_view(), model_view());
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc("idle_no_req", 0, 0, 0, 1, 1, 0, 'h44, 0);
        cyc("start_after_reset", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("step_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        #2;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
